// File: rtl/mul_approx_pipe.sv
// ---------------------------------------------------------------------------
// mul_approx_pipe
//
// Pipelined unsigned approximate multiplier with valid/ready handshakes on
// both sides and bubble-collapsing pipeline registers.
//
// In approximate mode every partial-product bit A[i]&B[j] whose column i+j is
// below TRUNC is dropped before summation (broken-array multiplier), so the
// low TRUNC bits of the result are always zero. Setting in_exact for a
// transaction selects the full product A*B instead.
//
// Optional feature (compile-time macro MUL_APPROX_COMP_EN):
//   When defined, approximate results get the constant bias 1<<(TRUNC-1)
//   added (no bias when TRUNC=0), saturating at 2^(2*WIDTH)-1. This recentres
//   the truncation error around zero. Exact results are never biased.
//   When undefined, the approximate result is the plain truncated sum.
//
// Parameters:
//   WIDTH   operand width (>=2); product is 2*WIDTH bits
//   TRUNC   number of low partial-product columns dropped in approx mode
//   STAGES  number of pipeline register stages (>=1); accept-to-output
//           latency is exactly STAGES cycles when not back-pressured
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous reset, active-high; empties the pipeline
//   in_valid   operand pair valid
//   in_ready   pipeline can accept an operand pair this cycle
//   in_exact   1 = exact product for this transaction, 0 = approximate
//   A, B       unsigned operands, sampled only on in_valid && in_ready
//   out_valid  O holds a valid result
//   out_ready  consumer accepts O this cycle
//   O          product, 2*WIDTH bits, held stable while stalled
// ---------------------------------------------------------------------------
module mul_approx_pipe #(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_exact,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   O
);

  localparam int PW = 2 * WIDTH;

  // Columns at or above TRUNC survive in approximate mode. Masking each
  // shifted row with this is the same as dropping every A[i]&B[j] with
  // i+j < TRUNC, because a row bit at position p is exactly the term with
  // i+j = p.
  localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << TRUNC;

`ifdef MUL_APPROX_COMP_EN
  // Half an LSB of the first kept column; zero when nothing is truncated.
  localparam logic [PW:0] BIAS =
    (TRUNC > 0) ? ((PW + 1)'(1) << ((TRUNC > 0) ? (TRUNC - 1) : 0)) : '0;
`endif

  logic [PW-1:0] col_mask;
  logic [PW-1:0] pp_sum;
  logic [PW-1:0] product;
`ifdef MUL_APPROX_COMP_EN
  logic [PW:0]   biased;
`endif

  logic [STAGES-1:0] valid_q;
  logic [PW-1:0]     data_q [STAGES];
  logic [STAGES-1:0] stage_load;
  logic              downstream_free;

  // Product generation for the operand pair at the input. Each multiplicand
  // bit selects one shifted copy of B; rows are masked down to the kept
  // columns before accumulation. The accumulated value can never exceed
  // A*B, so the 2*WIDTH-bit sum cannot wrap.
  always_comb begin
    col_mask = in_exact ? {PW{1'b1}} : KEEP_MASK;
    pp_sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (A[i]) begin
        pp_sum = pp_sum + (({{WIDTH{1'b0}}, B} << i) & col_mask);
      end
    end
`ifdef MUL_APPROX_COMP_EN
    biased  = {1'b0, pp_sum} + (in_exact ? {(PW + 1){1'b0}} : BIAS);
    product = biased[PW] ? {PW{1'b1}} : biased[PW-1:0];
`else
    product = pp_sum;
`endif
  end

  // Load enables, resolved from the output back towards the input. A stage
  // may load if it is empty or if everything downstream of it will move this
  // cycle; the running flag carries "some slot further on frees up" so that
  // an empty stage absorbs data even when the output is stalled.
  always_comb begin
    downstream_free = out_ready;
    stage_load      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      downstream_free = downstream_free || !valid_q[k];
      stage_load[k]   = downstream_free;
    end
  end

  assign in_ready  = stage_load[0];
  assign out_valid = valid_q[STAGES-1];
  assign O         = data_q[STAGES-1];

  // Pipeline registers. Data is only overwritten when a valid item arrives,
  // so a stalled last stage keeps O stable and bubbles do not disturb data.
  // Reset empties every stage and clears all data so O reads zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (stage_load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= product;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stage_load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k] <= data_q[k-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_approx_pipe.sv
// ---------------------------------------------------------------------------
// tb_mul_approx_pipe
//
// Self-checking bench for mul_approx_pipe. The main instance uses
// WIDTH=8, TRUNC=4, STAGES=2. Two further instances (WIDTH=4/TRUNC=0/
// STAGES=4 and WIDTH=12/TRUNC=7/STAGES=1) run free random traffic alongside.
// Expected products come from a bit-level partial-product reference
// function; expected results are queued in acceptance order and compared at
// the output.
// ---------------------------------------------------------------------------
module tb_mul_approx_pipe;

  localparam int W  = 8;
  localparam int T  = 4;
  localparam int S  = 2;
  localparam int PW = 2 * W;

  localparam int XW = 4;
  localparam int XT = 0;
  localparam int XS = 4;
  localparam int YW = 12;
  localparam int YT = 7;
  localparam int YS = 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_exact;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] O;

  logic            x_in_valid, x_in_ready, x_in_exact, x_out_valid, x_out_ready;
  logic [XW-1:0]   x_a, x_b;
  logic [2*XW-1:0] x_o;
  logic            y_in_valid, y_in_ready, y_in_exact, y_out_valid, y_out_ready;
  logic [YW-1:0]   y_a, y_b;
  logic [2*YW-1:0] y_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pops     = 0;
  int last_stall = -1;

  logic [63:0]   exp_q [$];
  int            acc_q [$];
  logic [63:0]   x_q [$];
  logic [63:0]   y_q [$];
  bit            held_pending = 0;
  logic [PW-1:0] held_val;
  bit            extra_run = 1;

  mul_approx_pipe #(.WIDTH(W), .TRUNC(T), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_exact(in_exact), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .O(O)
  );

  mul_approx_pipe #(.WIDTH(XW), .TRUNC(XT), .STAGES(XS)) dut_x (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .in_exact(x_in_exact), .A(x_a), .B(x_b), .out_valid(x_out_valid),
    .out_ready(x_out_ready), .O(x_o)
  );

  mul_approx_pipe #(.WIDTH(YW), .TRUNC(YT), .STAGES(YS)) dut_y (
    .clk(clk), .rst(rst), .in_valid(y_in_valid), .in_ready(y_in_ready),
    .in_exact(y_in_exact), .A(y_a), .B(y_b), .out_valid(y_out_valid),
    .out_ready(y_out_ready), .O(y_o)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure accept-to-output latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference product: sum every partial-product bit individually, skipping
  // columns below t in approximate mode, then apply the optional bias.
  function automatic longint model(input longint a, input longint b,
                                   input bit exact, input int w, input int t);
    longint s;
    longint maxv;
    s    = 0;
    maxv = (longint'(1) << (2 * w)) - 1;
    for (int i = 0; i < w; i++) begin
      for (int j = 0; j < w; j++) begin
        if (a[i] && b[j] && (exact || (i + j) >= t)) s += longint'(1) << (i + j);
      end
    end
`ifdef MUL_APPROX_COMP_EN
    if (!exact && t > 0) begin
      s += longint'(1) << (t - 1);
      if (s > maxv) s = maxv;
    end
`endif
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failNote(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  // Drive one operand pair and hold it until the pipeline accepts it.
  // Returns 1 time unit after the accepting clock edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ex);
    int n;
    A        = a;
    B        = b;
    in_exact = ex;
    in_valid = 1;
    n        = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        failNote("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  // Send one transaction on an idle pipeline and compare its result with a
  // hand-computed literal.
  task automatic directedCase(input string name, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic ex,
                              input longint expected);
    int n;
    applyStimulus(a, b, ex);
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid || n > 20) break;
      n++;
    end
    if (!out_valid) failNote({name, "_timeout"});
    else checkOutput(name, 64'(O), 64'(expected));
    @(posedge clk);
    #1;
  endtask

  // Main scoreboard: checks in_ready against pipeline occupancy, output
  // stability under back-pressure, result values in order, and exact
  // latency for items that never saw back-pressure.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      held_pending = 0;
    end else begin
      if (held_pending) begin
        checkOutput("hold_valid", 64'(out_valid), 64'(1));
        checkOutput("hold_O", 64'(O), 64'(held_val));
      end
      checkOutput("in_ready", 64'(in_ready),
                  64'(out_ready || (exp_q.size() < S)));
      if (out_valid && exp_q.size() == 0) begin
        failNote("spurious_out_valid");
      end else if (out_valid && out_ready) begin
        logic [63:0] e;
        int          a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        pops++;
        checkOutput("O", 64'(O), e);
        if (last_stall < a) checkOutput("latency", 64'(cyc - a), 64'(S));
      end
      if (!out_ready) last_stall = cyc;
      if (in_valid && in_ready) begin
        exp_q.push_back(64'(model(longint'(A), longint'(B), in_exact, W, T)));
        acc_q.push_back(cyc);
      end
      held_pending = out_valid && !out_ready;
      held_val     = O;
    end
  end

  // Scoreboards for the two side instances. The TRUNC=0 instance is checked
  // against the plain product whatever the mode bit says.
  always @(negedge clk) begin
    if (rst) begin
      x_q.delete();
      y_q.delete();
    end else begin
      checkOutput("x_in_ready", 64'(x_in_ready), 64'(x_out_ready || (x_q.size() < XS)));
      if (x_out_valid && x_q.size() == 0) failNote("x_spurious_out_valid");
      else if (x_out_valid && x_out_ready) checkOutput("x_O", 64'(x_o), x_q.pop_front());
      if (x_in_valid && x_in_ready) x_q.push_back(64'(x_a) * 64'(x_b));

      checkOutput("y_in_ready", 64'(y_in_ready), 64'(y_out_ready || (y_q.size() < YS)));
      if (y_out_valid && y_q.size() == 0) failNote("y_spurious_out_valid");
      else if (y_out_valid && y_out_ready) checkOutput("y_O", 64'(y_o), y_q.pop_front());
      if (y_in_valid && y_in_ready)
        y_q.push_back(64'(model(longint'(y_a), longint'(y_b), y_in_exact, YW, YT)));
    end
  end

  // Random traffic for the side instances; stops and drains on request.
  initial begin
    x_in_valid = 0; x_in_exact = 0; x_a = '0; x_b = '0; x_out_ready = 1;
    y_in_valid = 0; y_in_exact = 0; y_a = '0; y_b = '0; y_out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      x_in_valid  = extra_run && ($urandom_range(0, 3) != 0);
      x_out_ready = !extra_run || ($urandom_range(0, 3) != 0);
      x_in_exact  = 1'($urandom);
      x_a         = XW'($urandom);
      x_b         = XW'($urandom);
      y_in_valid  = extra_run && ($urandom_range(0, 3) != 0);
      y_out_ready = !extra_run || ($urandom_range(0, 3) != 0);
      y_in_exact  = 1'($urandom);
      y_a         = ($urandom_range(0, 7) == 0) ? {YW{1'b1}} : YW'($urandom);
      y_b         = ($urandom_range(0, 7) == 0) ? {YW{1'b1}} : YW'($urandom);
    end
  end

  // Watchdog: the bench must never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int p0;
    int t0;
    int accepts;
    rst = 1; in_valid = 0; in_exact = 0; A = '0; B = '0; out_ready = 1;

    checkOutput("model_pin_255", 64'(model(255, 255, 0, 8, 4)),
`ifdef MUL_APPROX_COMP_EN
                64'(64984));
`else
                64'(64976));
`endif
    checkOutput("model_pin_exact", 64'(model(255, 255, 1, 8, 4)), 64'(65025));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_O", 64'(O), 64'(0));
    @(posedge clk);
    #1 rst = 0;
    #1 checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    $display("[TB] directed literal cases");
`ifdef MUL_APPROX_COMP_EN
    directedCase("lit_255x255_approx", 8'd255, 8'd255, 1'b0, 64984);
    directedCase("lit_15x15_approx", 8'd15, 8'd15, 1'b0, 184);
    directedCase("lit_1x1_approx", 8'd1, 8'd1, 1'b0, 8);
`else
    directedCase("lit_255x255_approx", 8'd255, 8'd255, 1'b0, 64976);
    directedCase("lit_15x15_approx", 8'd15, 8'd15, 1'b0, 176);
    directedCase("lit_1x1_approx", 8'd1, 8'd1, 1'b0, 0);
`endif
    directedCase("lit_1x1_exact", 8'd1, 8'd1, 1'b1, 1);
    directedCase("lit_255x255_exact", 8'd255, 8'd255, 1'b1, 65025);

    $display("[TB] back-to-back 100 random pairs");
    p0 = pops;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
    end
    checkOutput("b2b_cycles", 64'(cyc - t0), 64'(100));
    repeat (S + 2) @(posedge clk);
    #1 checkOutput("b2b_count", 64'(pops - p0), 64'(100));

    $display("[TB] fill under back-pressure");
    out_ready = 0;
    in_valid  = 1;
    accepts   = 0;
    for (int i = 0; i < 6; i++) begin
      A = W'($urandom); B = W'($urandom); in_exact = 1'($urandom);
      @(negedge clk);
      if (in_ready) accepts++;
      @(posedge clk);
      #1;
    end
    checkOutput("fill_accepts", 64'(accepts), 64'(S));
    checkOutput("fill_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1;
    #1 checkOutput("pop_push_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      A = W'($urandom); B = W'($urandom); in_exact = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    repeat (S + 2) @(posedge clk);
    #1 checkOutput("fill_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] random traffic with random back-pressure");
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_exact  = 1'($urandom);
      A = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
      B = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 0;
    out_ready = 1;
    repeat (S + 2) @(posedge clk);
    #1 checkOutput("random_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] reset with transactions in flight");
    out_ready = 0;
    applyStimulus(8'd200, 8'd100, 1'b1);
    applyStimulus(8'd77, 8'd99, 1'b0);
    in_valid = 1;
    A = 8'd3; B = 8'd5; in_exact = 1;
    #1 rst = 1;
    #1;
    checkOutput("rst_mid_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_mid_O", 64'(O), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1;
    in_valid  = 0;
    rst       = 0;
    repeat (6) @(posedge clk);
    #1 checkOutput("post_rst_idle", 64'(out_valid), 64'(0));

    extra_run = 0;
    repeat (XS + 4) @(posedge clk);
    #1;
    checkOutput("x_drained", 64'(x_q.size()), 64'(0));
    checkOutput("y_drained", 64'(y_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
